pip_compositor: RTL and testbench
=================================

PIP_COMPOSITOR -- requirements
Module: pip_compositor

Interface
REQ-001 Parameter NUM_CH, default 2, total channels (2..4); channel 0 is the full-screen background, channels 1..NUM_CH-1 are overlays.
REQ-002 Parameter COORD_W, default 11, width of X/Y coordinates and window geometry fields.
REQ-003 Parameter PIX_W, default 16, pixel width (RGB565).
REQ-004 Parameter LEAD, default 2, cycles from oRD_REQ high to matching iRD_DATA valid (1..4).
REQ-005 Parameters H_ACT, default 640, and V_ACT, default 480, active display size.
REQ-006 iCLK  in  1  pixel clock; one clock, all logic on its rising edge.
REQ-007 iRST  in  1  reset, synchronous, active-high.
REQ-008 iX, iY  in  COORD_W each  current display coordinate from the VGA timing generator.
REQ-009 iDE  in  1  active-video qualifier for iX/iY.
REQ-010 iFRAME_START  in  1  one-cycle pulse before the first active line.
REQ-011 iWIN_X, iWIN_Y, iWIN_W, iWIN_H  in  NUM_CH*COORD_W each  overlay window geometry; channel 0 slot ignored.
REQ-012 iWIN_EN  in  NUM_CH  overlay enables; bit 0 ignored.
REQ-013 iBORDER_EN  in  1  draw 1-pixel border on overlay edges.
REQ-014 iBORDER_COLOR  in  PIX_W  border pixel value.
REQ-015 iRD_DATA  in  NUM_CH*PIX_W  per-channel frame-buffer read data.
REQ-016 oRD_REQ  out  NUM_CH  per-channel frame-buffer read request.
REQ-017 oPIX  out  PIX_W  composited pixel.
REQ-018 oPIX_VALID  out  1  oPIX qualifier.
REQ-019 oCFG_ERR  out  NUM_CH  per-channel window rejected for the current frame.

Function
REQ-020 Geometry and enables SHALL be captured into shadow registers on iFRAME_START only; changes at other times have no effect until the next iFRAME_START.
REQ-021 Overlay k is active for the frame if enabled, W>0, H>0, X+W<=H_ACT and Y+H<=V_ACT, with sums computed at COORD_W+1 bits; otherwise disabled and oCFG_ERR[k] set until the next iFRAME_START.
REQ-022 Pixel (x,y) is inside window k when X<=x<X+W and Y<=y<Y+H.
REQ-023 oRD_REQ[0] SHALL be high at cycle t+1 for every cycle t with iDE high.
REQ-024 oRD_REQ[k] SHALL be high at t+1 for every iDE cycle inside active window k, including occluded and border pixels, so each FIFO is drained exactly W*H words per frame.
REQ-025 Topmost channel = highest-index active window containing the pixel, else channel 0; select delayed through a LEAD+1-stage pipeline aligned to iRD_DATA.
REQ-026 oPIX/oPIX_VALID SHALL be registered at t+LEAD+2 for input cycle t; oPIX_VALID mirrors delayed iDE; oPIX = 0 when oPIX_VALID is low.
REQ-027 With iBORDER_EN high, the first/last row and column of the topmost overlay output iBORDER_COLOR instead of data; the read is still issued.
REQ-028 Overlapping windows: only the topmost is displayed; all overlapping channels still request.
REQ-029 iFRAME_START coincident with iDE: shadow update takes priority; the pixel uses the new configuration.

Reset
REQ-030 On iRST: oRD_REQ=0, oPIX=0, oPIX_VALID=0, oCFG_ERR=0, pipelines cleared, all overlay shadows disabled.
REQ-031 After reset, overlays stay off until the first iFRAME_START; the background is requested from the first iDE cycle.
REQ-032 iRST mid-frame SHALL take effect the next cycle and discard any in-flight pipeline contents.

Structure
REQ-033 Package pip_pkg SHALL hold the default H_ACT/V_ACT, the LEAD bounds, and the channel-select width function clog2(NUM_CH).
REQ-034 Sub-module pip_window_match SHALL be instantiated once per overlay: shadow registers, validity check, inside and edge detection.
REQ-035 Channel-select mux and delay pipeline SHALL reside in pip_compositor.

Verification
REQ-036 NUM_CH=2, LEAD=2, win1=(310,230,320,240) enabled, full 640x480 frame -> oRD_REQ[1] count 76800, oRD_REQ[0] count 307200, oPIX=ch1 data exactly for x 310..629, y 230..469.
REQ-037 Same setup, iBORDER_EN=1, color 16'hF800 -> (310,230), (629,469), (400,230) output F800; (311,231) outputs ch1 data; request counts unchanged.
REQ-038 win1=(400,300,300,100) -> oCFG_ERR[1]=1, zero ch1 requests, all output from ch0.
REQ-039 NUM_CH=3, win1=(100,100,200,200), win2=(200,200,200,200) -> at (250,250) output ch2; ch1 requests=40000, ch2 requests=40000.
REQ-040 Change win1 X at line 100 -> no effect until the next iFRAME_START; iRST at pixel (50,50) -> outputs 0 next cycle, overlays off until the next frame start.

Source files
------------

// File: rtl/pip_pkg.sv
// pip_pkg: shared defaults, read-lead bounds and select-width helper for the PiP compositor.
package pip_pkg;
  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int LEAD_MIN = 1;
  localparam int LEAD_MAX = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/pip_compositor_if.sv
// pip_compositor_if: timing, window configuration, frame-buffer and pixel-out bundle.
interface pip_compositor_if #(
  parameter int NUM_CH = 2,
  parameter int COORD_W = 11,
  parameter int PIX_W = 16
);
  logic [COORD_W-1:0] iX;
  logic [COORD_W-1:0] iY;
  logic iDE;
  logic iFRAME_START;
  logic [NUM_CH*COORD_W-1:0] iWIN_X;
  logic [NUM_CH*COORD_W-1:0] iWIN_Y;
  logic [NUM_CH*COORD_W-1:0] iWIN_W;
  logic [NUM_CH*COORD_W-1:0] iWIN_H;
  logic [NUM_CH-1:0] iWIN_EN;
  logic iBORDER_EN;
  logic [PIX_W-1:0] iBORDER_COLOR;
  logic [NUM_CH*PIX_W-1:0] iRD_DATA;
  logic [NUM_CH-1:0] oRD_REQ;
  logic [PIX_W-1:0] oPIX;
  logic oPIX_VALID;
  logic [NUM_CH-1:0] oCFG_ERR;
  modport master (
    output iX, iY, iDE, iFRAME_START, iWIN_X, iWIN_Y, iWIN_W, iWIN_H, iWIN_EN,
    output iBORDER_EN, iBORDER_COLOR, iRD_DATA,
    input oRD_REQ, oPIX, oPIX_VALID, oCFG_ERR
  );
  modport slave (
    input iX, iY, iDE, iFRAME_START, iWIN_X, iWIN_Y, iWIN_W, iWIN_H, iWIN_EN,
    input iBORDER_EN, iBORDER_COLOR, iRD_DATA,
    output oRD_REQ, oPIX, oPIX_VALID, oCFG_ERR
  );
endinterface

// File: rtl/pip_window_match.sv
// pip_window_match: per-overlay shadow geometry, validity check, inside and edge detection.
module pip_window_match
  import pip_pkg::*;
#(
  parameter int COORD_W = 11,
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               frame_start_i,
  input  logic               en_i,
  input  logic [COORD_W-1:0] win_x_i,
  input  logic [COORD_W-1:0] win_y_i,
  input  logic [COORD_W-1:0] win_w_i,
  input  logic [COORD_W-1:0] win_h_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic               hit_o,
  output logic               edge_o,
  output logic               err_o
);
  localparam int S = COORD_W + 1;
  localparam logic [S-1:0] ONE = S'(1);
  logic [COORD_W-1:0] x_q, y_q, w_q, h_q, x_d, y_d, w_d, h_d;
  logic act_q, act_d, err_q, err_d, ok;
  logic [S-1:0] xe_n, ye_n, xe, ye;
  assign xe_n = {1'b0, win_x_i} + {1'b0, win_w_i};
  assign ye_n = {1'b0, win_y_i} + {1'b0, win_h_i};
  assign ok = en_i && (win_w_i != '0) && (win_h_i != '0) && (xe_n <= S'(H_ACT)) && (ye_n <= S'(V_ACT));
  // The frame-start cycle already matches against the incoming configuration.
  always_comb begin
    x_d = frame_start_i ? win_x_i : x_q;
    y_d = frame_start_i ? win_y_i : y_q;
    w_d = frame_start_i ? win_w_i : w_q;
    h_d = frame_start_i ? win_h_i : h_q;
    act_d = frame_start_i ? ok : act_q;
    err_d = frame_start_i ? (en_i && !ok) : err_q;
  end
  assign xe = {1'b0, x_d} + {1'b0, w_d};
  assign ye = {1'b0, y_d} + {1'b0, h_d};
  assign hit_o = act_d && (x_i >= x_d) && ({1'b0, x_i} < xe) && (y_i >= y_d) && ({1'b0, y_i} < ye);
  assign edge_o = (x_i == x_d) || ({1'b0, x_i} == xe - ONE) || (y_i == y_d) || ({1'b0, y_i} == ye - ONE);
  assign err_o = err_q;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_q <= '0;
      y_q <= '0;
      w_q <= '0;
      h_q <= '0;
      act_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      w_q <= w_d;
      h_q <= h_d;
      act_q <= act_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/pip_compositor.sv
// pip_compositor: issues per-channel frame-buffer reads and composites the topmost window per pixel.
module pip_compositor
  import pip_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int COORD_W = 11,
  parameter int PIX_W = 16,
  parameter int LEAD = 2,
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF
) (
  input logic iCLK,
  input logic iRST,
  pip_compositor_if.slave bus
);
  localparam int SEL_W = clog2(NUM_CH);
  localparam int LD = (LEAD < LEAD_MIN) ? LEAD_MIN : (LEAD > LEAD_MAX) ? LEAD_MAX : LEAD;
  logic [NUM_CH-1:0] hit, edg, err;
  logic [SEL_W-1:0] sel_d;
  logic brd_d;
  logic [NUM_CH-1:0] req_q;
  logic [LD:0] de_q, brd_q;
  logic [SEL_W-1:0] sel_q [LD+1];
  logic [PIX_W-1:0] rd_w, pix_d, pix_q;
  logic vld_q;
  assign hit[0] = 1'b1;
  assign edg[0] = 1'b0;
  assign err[0] = 1'b0;
  genvar k;
  for (k = 1; k < NUM_CH; k++) begin : g_win
    pip_window_match #(.COORD_W(COORD_W), .H_ACT(H_ACT), .V_ACT(V_ACT)) u_win (
      .iCLK(iCLK),
      .iRST(iRST),
      .frame_start_i(bus.iFRAME_START),
      .en_i(bus.iWIN_EN[k]),
      .win_x_i(bus.iWIN_X[k*COORD_W +: COORD_W]),
      .win_y_i(bus.iWIN_Y[k*COORD_W +: COORD_W]),
      .win_w_i(bus.iWIN_W[k*COORD_W +: COORD_W]),
      .win_h_i(bus.iWIN_H[k*COORD_W +: COORD_W]),
      .x_i(bus.iX),
      .y_i(bus.iY),
      .hit_o(hit[k]),
      .edge_o(edg[k]),
      .err_o(err[k])
    );
  end
  always_comb begin
    sel_d = '0;
    for (int i = 1; i < NUM_CH; i++) if (hit[i]) sel_d = SEL_W'(i);
    brd_d = bus.iBORDER_EN && (sel_d != '0) && edg[sel_d];
  end
  // Stage LD of the select pipe lines up with the read data returned for that pixel.
  always_comb begin
    rd_w = '0;
    for (int i = 0; i < NUM_CH; i++) if (sel_q[LD] == SEL_W'(i)) rd_w = bus.iRD_DATA[i*PIX_W +: PIX_W];
    pix_d = de_q[LD] ? (brd_q[LD] ? bus.iBORDER_COLOR : rd_w) : '0;
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      req_q <= '0;
      de_q <= '0;
      brd_q <= '0;
      for (int i = 0; i <= LD; i++) sel_q[i] <= '0;
      pix_q <= '0;
      vld_q <= 1'b0;
    end else begin
      req_q <= {NUM_CH{bus.iDE}} & hit;
      de_q <= {de_q[LD-1:0], bus.iDE};
      brd_q <= {brd_q[LD-1:0], brd_d};
      sel_q[0] <= sel_d;
      for (int i = 1; i <= LD; i++) sel_q[i] <= sel_q[i-1];
      pix_q <= pix_d;
      vld_q <= de_q[LD];
    end
  end
  assign bus.oRD_REQ = req_q;
  assign bus.oPIX = pix_q;
  assign bus.oPIX_VALID = vld_q;
  assign bus.oCFG_ERR = err;
endmodule

// File: tb/tb_pip_compositor.sv
// tb_pip_compositor: randomized frames against a window-geometry reference model with queued expectations.
module tb_pip_compositor;
  localparam int NC = 3;
  localparam int CW = 11;
  localparam int PW = 16;
  localparam int LD = 2;
  localparam int HA = 64;
  localparam int VA = 48;
  logic clk, rst;
  pip_compositor_if #(.NUM_CH(NC), .COORD_W(CW), .PIX_W(PW)) bus ();
  pip_compositor #(.NUM_CH(NC), .COORD_W(CW), .PIX_W(PW), .LEAD(LD), .H_ACT(HA), .V_ACT(VA)) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk, n_fail, cyc, px_prev, py_prev;
  int cnt [NC];
  int sx [NC], sy [NC], sw [NC], sh [NC];
  bit act [NC];
  logic [NC-1:0] ev;
  logic [15:0] seed;
  logic [PW-1:0] dd [8][NC];
  bit dv [8][NC];
  logic [NC-1:0] rq [$];
  logic [PW-1:0] pq [$];
  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, a, e);
    end
  endtask
  function automatic logic [PW-1:0] hdat(input int k, input int x, input int y);
    return PW'(int'(seed) ^ (k * 40503) ^ (x * 31) ^ (y * 1237) ^ (k << 13));
  endfunction
  function automatic bit inside_w(input int k, input int x, input int y);
    return x >= sx[k] && x < sx[k] + sw[k] && y >= sy[k] && y < sy[k] + sh[k];
  endfunction
  function automatic bit on_edge(input int k, input int x, input int y);
    return x == sx[k] || x == sx[k] + sw[k] - 1 || y == sy[k] || y == sy[k] + sh[k] - 1;
  endfunction
  initial begin
    logic [NC-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        check("rd_req", 32'(bus.oRD_REQ), 32'(e));
      end
      if (bus.oPIX_VALID === 1'b1) begin
        if (pq.size() == 0) check("pix_unexpected", 32'(bus.oPIX_VALID), 32'd0);
        else check("pix", 32'(bus.oPIX), 32'(pq.pop_front()));
      end else begin
        check("pix_idle", 32'({bus.oPIX_VALID, bus.oPIX}), 32'd0);
      end
    end
  end
  task automatic step(input bit rst_v, input bit fs, input bit de, input int x, input int y);
    logic [NC-1:0] req, er;
    logic [NC*PW-1:0] rd;
    int top, s;
    bit valid;
    @(posedge clk);
    #2;
    check("cfg_err", 32'(bus.oCFG_ERR), 32'(ev));
    req = bus.oRD_REQ;
    s = cyc % 8;
    for (int k = 0; k < NC; k++) begin
      cnt[k] += int'(req[k]);
      rd[k*PW +: PW] = dv[s][k] ? dd[s][k] : PW'($urandom);
      dv[s][k] = 1'b0;
    end
    for (int k = 0; k < NC; k++) if (req[k]) begin
      dv[(cyc + LD) % 8][k] = 1'b1;
      dd[(cyc + LD) % 8][k] = hdat(k, px_prev, py_prev);
    end
    bus.iRD_DATA = rd;
    rst = rst_v;
    bus.iFRAME_START = fs;
    bus.iDE = de;
    bus.iX = CW'(x);
    bus.iY = CW'(y);
    if (rst_v) begin
      for (int k = 0; k < NC; k++) act[k] = 1'b0;
      ev = '0;
      pq.delete();
      rq.push_back('0);
    end else begin
      if (fs) for (int k = 1; k < NC; k++) begin
        sx[k] = int'(bus.iWIN_X[k*CW +: CW]);
        sy[k] = int'(bus.iWIN_Y[k*CW +: CW]);
        sw[k] = int'(bus.iWIN_W[k*CW +: CW]);
        sh[k] = int'(bus.iWIN_H[k*CW +: CW]);
        valid = sw[k] > 0 && sh[k] > 0 && sx[k] + sw[k] <= HA && sy[k] + sh[k] <= VA;
        act[k] = bus.iWIN_EN[k] && valid;
        ev[k] = bus.iWIN_EN[k] && !valid;
      end
      er = '0;
      top = 0;
      if (de) begin
        er[0] = 1'b1;
        for (int k = 1; k < NC; k++) if (act[k] && inside_w(k, x, y)) begin
          er[k] = 1'b1;
          top = k;
        end
        pq.push_back((bus.iBORDER_EN && top > 0 && on_edge(top, x, y)) ? bus.iBORDER_COLOR : hdat(top, x, y));
      end
      rq.push_back(er);
    end
    px_prev = x;
    py_prev = y;
    cyc++;
  endtask
  task automatic setwin(input int k, input int x, input int y, input int w, input int h, input bit en);
    bus.iWIN_X[k*CW +: CW] = CW'(x);
    bus.iWIN_Y[k*CW +: CW] = CW'(y);
    bus.iWIN_W[k*CW +: CW] = CW'(w);
    bus.iWIN_H[k*CW +: CW] = CW'(h);
    bus.iWIN_EN[k] = en;
  endtask
  task automatic frame(input bit do_fs, input bit fs_de, input int chg_y, input int rst_x, input int rst_y);
    for (int k = 0; k < NC; k++) cnt[k] = 0;
    if (do_fs && !fs_de) step(0, 1, 0, 0, 0);
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        if (y == chg_y && x == 0) bus.iWIN_X[CW +: CW] = CW'($urandom_range(0, HA - 1));
        if (x == rst_x && y == rst_y) begin
          step(1, 0, 1, x, y);
          return;
        end
        step(0, do_fs && fs_de && x == 0 && y == 0, 1, x, y);
      end
      repeat (4) step(0, 0, 0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
    end
    repeat (LD + 4) step(0, 0, 0, 0, 0);
    check("req_cnt0", 32'(cnt[0]), 32'(HA * VA));
    for (int k = 1; k < NC; k++) check($sformatf("req_cnt%0d", k), 32'(cnt[k]), act[k] ? 32'(sw[k] * sh[k]) : 32'd0);
    check("pix_drain", 32'(pq.size()), 32'd0);
  endtask
  initial begin
    int x, w, y, h;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    px_prev = 0;
    py_prev = 0;
    ev = '0;
    seed = 16'($urandom);
    for (int k = 0; k < NC; k++) begin
      act[k] = 1'b0;
      sx[k] = 0; sy[k] = 0; sw[k] = 0; sh[k] = 0;
    end
    for (int s = 0; s < 8; s++) for (int k = 0; k < NC; k++) dv[s][k] = 1'b0;
    rst = 1'b1;
    bus.iX = '0;
    bus.iY = '0;
    bus.iDE = 1'b0;
    bus.iFRAME_START = 1'b0;
    bus.iWIN_X = '0;
    bus.iWIN_Y = '0;
    bus.iWIN_W = '0;
    bus.iWIN_H = '0;
    bus.iWIN_EN = '0;
    bus.iBORDER_EN = 1'b0;
    bus.iBORDER_COLOR = 16'hF800;
    bus.iRD_DATA = '0;
    repeat (3) step(1, 0, 0, 0, 0);
    setwin(1, 20, 15, 30, 20, 1);
    frame(0, 0, -1, -1, -1);
    frame(1, 0, -1, -1, -1);
    bus.iBORDER_EN = 1'b1;
    frame(1, 0, -1, -1, -1);
    setwin(1, 40, 30, 30, 10, 1);
    frame(1, 0, -1, -1, -1);
    setwin(1, 10, 10, 20, 20, 1);
    setwin(2, 20, 20, 20, 20, 1);
    frame(1, 0, 20, -1, -1);
    frame(1, 1, -1, -1, -1);
    setwin(1, 0, 0, HA, VA, 1);
    setwin(2, HA - 1, VA - 1, 1, 1, 1);
    frame(1, 0, -1, -1, -1);
    setwin(1, 10, 10, 0, 5, 1);
    setwin(2, 2000, 0, 100, 1, 1);
    frame(1, 0, -1, -1, -1);
    setwin(1, 5, 5, 40, 30, 1);
    setwin(2, 30, 20, 20, 20, 1);
    frame(1, 0, -1, 30, 30);
    frame(0, 0, -1, -1, -1);
    frame(1, 0, -1, -1, -1);
    repeat (4) begin
      for (int k = 1; k < NC; k++) begin
        x = int'($urandom_range(0, HA - 1));
        y = int'($urandom_range(0, VA - 1));
        w = int'($urandom_range(0, HA - x + 2));
        h = int'($urandom_range(0, VA - y + 2));
        setwin(k, x, y, w, h, 1'($urandom_range(0, 3) != 0));
      end
      bus.iBORDER_EN = 1'($urandom_range(0, 1));
      frame(1, 1'($urandom_range(0, 1)), -1, -1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
